seg7_scan: RTL and testbench

- Downstream display stage for the 4-bit loadable counter slice (Q/CO).
- Takes DIGITS cascaded counter outputs, packed as 4-bit digits, and time-multiplexes them onto one common-anode 7-segment bank.
- Holds a sticky overflow flag driven by the top slice's CO; the flag lights the decimal point of digit 0.
- Frame-coherent: digit values are snapshotted once per scan frame, so the display never tears mid-frame.

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_hex_decode.sv | 18 +
 rtl/seg7_scan.sv | 125 ++++++++++++
 tb/tb_seg7_scan.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// ============================================================================
// seg7_pkg : shared constants and types for the seg7_scan display block.
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Common-anode hex glyphs, active-low {g,f,e,d,c,b,a}; entry 0 is leftmost.
  localparam logic [0:15][6:0] SEG_TABLE = {
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seg7_hex_decode.sv
// ============================================================================
// seg7_hex_decode : combinational 4-bit hex to active-low 7-segment lookup.
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

`default_nettype wire

// File: rtl/seg7_scan.sv
// ============================================================================
// seg7_scan : frame-coherent multiplexed 7-segment driver with sticky overflow.
// Optional leading-zero blanking when SEG7_LZB_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DIV_W    = 16
) (
  input  logic                  CLK,
  input  logic                  MR,
  input  logic [4*DIGITS-1:0]   D_IN,
  input  logic                  CO_IN,
  input  logic                  CLR_OVF,
  output logic [6:0]            SEG,
  output logic                  DP,
  output logic [DIGITS-1:0]     AN,
  output logic                  OVF
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  state_t              state;
  logic [DIV_W-1:0]    presc;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] shadow;
  logic                tick;
  logic                last;
  logic [3:0]          digit;
  logic [6:0]          hex_seg;
  logic                blank_digit;
  logic [DIGITS-1:0]   an_next;

  assign tick  = (presc == DIV_LAST);
  assign last  = (idx == '0);
  assign digit = 4'(shadow >> {idx, 2'b00});

  always_comb begin
    an_next = '1;
    for (int i = 0; i < DIGITS; i++) begin
      an_next[i] = (idx != IDX_W'(i));
    end
  end

  seg7_hex_decode u_dec (
    .hex (digit),
    .seg (hex_seg)
  );

`ifdef SEG7_LZB_EN
  logic lz;

  assign blank_digit = lz && (digit == 4'd0) && !last;

  // A frame boundary re-arms blanking; any shown nonzero digit or digit 0 ends it.
  always_ff @(posedge CLK) begin
    if (MR) begin
      lz <= 1'b1;
    end else if (state == IDLE) begin
      lz <= 1'b1;
    end else if (tick && last) begin
      lz <= 1'b1;
    end else if ((digit != 4'd0) || last) begin
      lz <= 1'b0;
    end
  end
`else
  assign blank_digit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (MR) begin
      SEG    <= SEG_BLANK;
      DP     <= 1'b1;
      AN     <= '1;
      OVF    <= 1'b0;
      presc  <= '0;
      idx    <= IDX_TOP;
      shadow <= '0;
      state  <= IDLE;
    end else begin
      if (CO_IN) begin
        OVF <= 1'b1;
      end else if (CLR_OVF) begin
        OVF <= 1'b0;
      end

      case (state)
        IDLE: begin
          shadow <= D_IN;
          presc  <= '0;
          idx    <= IDX_TOP;
          SEG    <= SEG_BLANK;
          DP     <= 1'b1;
          AN     <= '1;
          state  <= SCAN;
        end
        SCAN: begin
          presc <= tick ? '0 : presc + 1'b1;
          if (tick) begin
            if (last) begin
              idx    <= IDX_TOP;
              shadow <= D_IN;
            end else begin
              idx <= idx - 1'b1;
            end
          end
          AN  <= an_next;
          SEG <= blank_digit ? SEG_BLANK : hex_seg;
          DP  <= last ? ~OVF : 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan.sv
// ============================================================================
// tb_seg7_scan : directed self-checking bench for seg7_scan (DIGITS=4, SCAN_DIV=4).
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan;

  logic        clk;
  logic        mr;
  logic [15:0] d_in;
  logic        co_in;
  logic        clr_ovf;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        ovf;

  int n_checks = 0;
  int n_err    = 0;

`ifdef SEG7_LZB_EN
  localparam logic [27:0] EXP_0040 = {7'h7F, 7'h7F, 7'h19, 7'h40};
  localparam logic [27:0] EXP_0401 = {7'h7F, 7'h19, 7'h40, 7'h79};
`else
  localparam logic [27:0] EXP_0040 = {7'h40, 7'h40, 7'h19, 7'h40};
  localparam logic [27:0] EXP_0401 = {7'h40, 7'h19, 7'h40, 7'h79};
`endif

  seg7_scan #(
    .DIGITS   (4),
    .SCAN_DIV (4),
    .DIV_W    (4)
  ) dut (
    .CLK     (clk),
    .MR      (mr),
    .D_IN    (d_in),
    .CO_IN   (co_in),
    .CLR_OVF (clr_ovf),
    .SEG     (seg),
    .DP      (dp),
    .AN      (an),
    .OVF     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full 16-cycle frame, digit 3 first; optional CO pulse and mid-frame D_IN change.
  task automatic frame(input string tag, input logic [27:0] segs, input logic dp0,
                       input logic co, input logic chg, input logic [15:0] chg_val);
    logic [3:0] ans [4];
    logic [6:0] s;
    ans = '{4'h7, 4'hB, 4'hD, 4'hE};
    for (int d = 0; d < 4; d++) begin
      s = segs[27 - 7*d -: 7];
      if (chg && d == 1) d_in = chg_val;
      for (int c = 0; c < 4; c++) begin
        if (co && d == 0 && c == 0) co_in = 1'b1;
        step();
        co_in = 1'b0;
        chk({tag, "_an"},  16'(an),  16'(ans[d]));
        chk({tag, "_seg"}, 16'(seg), 16'(s));
        chk({tag, "_dp"},  16'(dp),  16'((d == 3) ? dp0 : 1'b1));
        if (co && d == 0 && c == 0) chk({tag, "_ovf_set"}, 16'(ovf), 16'h1);
      end
    end
  endtask

  initial begin
    mr      = 1'b1;
    d_in    = 16'h1234;
    co_in   = 1'b0;
    clr_ovf = 1'b0;
    step();
    step();
    chk("rst_seg", 16'(seg), 16'h7F);
    chk("rst_an",  16'(an),  16'hF);
    chk("rst_dp",  16'(dp),  16'h1);
    chk("rst_ovf", 16'(ovf), 16'h0);

    mr = 1'b0;
    step();
    chk("idle_seg", 16'(seg), 16'h7F);
    chk("idle_an",  16'(an),  16'hF);
    chk("idle_dp",  16'(dp),  16'h1);

    frame("f1_1234", {7'h79, 7'h24, 7'h30, 7'h19}, 1'b1, 1'b0, 1'b0, 16'h0);
    d_in = 16'h0040;
    frame("f2_hold", {7'h79, 7'h24, 7'h30, 7'h19}, 1'b1, 1'b0, 1'b0, 16'h0);
    d_in = 16'h0401;
    frame("f3_0040", EXP_0040, 1'b1, 1'b0, 1'b0, 16'h0);
    d_in = 16'h1111;
    frame("f4_0401", EXP_0401, 1'b1, 1'b0, 1'b0, 16'h0);
    frame("f5_coh",  {7'h79, 7'h79, 7'h79, 7'h79}, 1'b1, 1'b0, 1'b1, 16'h2222);
    frame("f6_2222", {7'h24, 7'h24, 7'h24, 7'h24}, 1'b1, 1'b0, 1'b0, 16'h0);
    frame("f7_ovf",  {7'h24, 7'h24, 7'h24, 7'h24}, 1'b0, 1'b1, 1'b0, 16'h0);

    co_in   = 1'b1;
    clr_ovf = 1'b1;
    step();
    chk("ovf_set_wins", 16'(ovf), 16'h1);
    chk("ovf_an",       16'(an),  16'h7);
    co_in = 1'b0;
    step();
    chk("ovf_clear", 16'(ovf), 16'h0);
    clr_ovf = 1'b0;
    for (int k = 0; k < 7; k++) step();
    chk("mid_an",  16'(an),  16'hD);
    chk("mid_seg", 16'(seg), 16'h24);

    mr = 1'b1;
    step();
    chk("mr_mid_seg", 16'(seg), 16'h7F);
    chk("mr_mid_an",  16'(an),  16'hF);
    chk("mr_mid_dp",  16'(dp),  16'h1);
    mr = 1'b0;
    step();
    chk("mr_idle_seg", 16'(seg), 16'h7F);
    chk("mr_idle_an",  16'(an),  16'hF);
    frame("f8_restart", {7'h24, 7'h24, 7'h24, 7'h24}, 1'b1, 1'b0, 1'b0, 16'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
